// File: rtl/video_compositor_if.sv
// video_compositor_if: layer colours, VGA timing and hit pulse in; DAC pins and status out
// master: upstream side (VGA controller, layers, game logic) drives the inputs
// slave : the compositor, drives vga_r/g/b, vga_hs/vs, frame_tick, flash_active
interface video_compositor_if;
  logic        h_sync_i;
  logic        v_sync_i;
  logic        disp_ena_i;
  logic [11:0] stars_rgb;
  logic        stars_draw;
  logic [11:0] ast_rgb;
  logic        ast_draw;
  logic [11:0] ship_rgb;
  logic        ship_draw;
  logic        hit_i;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_tick;
  logic        flash_active;
  modport master (
    output h_sync_i, v_sync_i, disp_ena_i, stars_rgb, stars_draw, ast_rgb, ast_draw,
           ship_rgb, ship_draw, hit_i,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick, flash_active
  );
  modport slave (
    input  h_sync_i, v_sync_i, disp_ena_i, stars_rgb, stars_draw, ast_rgb, ast_draw,
           ship_rgb, ship_draw, hit_i,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick, flash_active
  );
endinterface

// File: rtl/video_compositor.sv
// video_compositor: fixed-priority layer merge, blanking, sync re-timing, frame tick, hit flash
// clk, reset : pixel clock, synchronous active-high reset
// bus        : video_compositor_if.slave (syncs/enable/layers/hit in, DAC/status out)
// Optional build macro VIDEO_COMPOSITOR_FLASH_EN adds the hit-flash FSM; without it
// hit_i is ignored and flash_active is tied low.
module video_compositor #(
  parameter int          LAYER_LAT    = 1,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [11:0] BG_RGB       = 12'h000
) (
  input logic               clk,
  input logic               reset,
  video_compositor_if.slave bus
);
  // each stage holds {h_sync, v_sync, disp_ena}; syncs idle high, enable idle low
  logic [LAYER_LAT-1:0][2:0] r_dl;
  logic                      r_hs;
  logic                      r_vs;
  logic [11:0]               r_rgb;
  logic                      r_vs_prev;
  logic                      r_tick;
  logic [2:0]                w_dl_out;
  logic [11:0]               w_pick;
  logic                      w_white;
  assign w_dl_out = r_dl[LAYER_LAT-1];
  always_comb w_pick = bus.ship_draw  ? bus.ship_rgb  :
                       bus.ast_draw   ? bus.ast_rgb   :
                       bus.stars_draw ? bus.stars_rgb : BG_RGB;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dl      <= {LAYER_LAT{3'b110}};
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_rgb     <= 12'h000;
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_dl[0] <= {bus.h_sync_i, bus.v_sync_i, bus.disp_ena_i};
      for (int k = 1; k < LAYER_LAT; k++) r_dl[k] <= r_dl[k-1];
      r_hs      <= w_dl_out[2];
      r_vs      <= w_dl_out[1];
      // blanking beats the flash, the flash beats the layers
      r_rgb     <= !w_dl_out[0] ? 12'h000 : w_white ? 12'hFFF : w_pick;
      r_vs_prev <= bus.v_sync_i;
      r_tick    <= r_vs_prev & ~bus.v_sync_i;
    end
  end
  assign bus.vga_r      = r_rgb[11:8];
  assign bus.vga_g      = r_rgb[7:4];
  assign bus.vga_b      = r_rgb[3:0];
  assign bus.vga_hs     = r_hs;
  assign bus.vga_vs     = r_vs;
  assign bus.frame_tick = r_tick;
`ifdef VIDEO_COMPOSITOR_FLASH_EN
  typedef enum logic {IDLE, FLASH} state_t;
  state_t     r_state;
  logic [7:0] r_fcnt;
  logic       r_flash;
  // a hit always restarts the flash, so a tick in the same cycle is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fcnt  <= 8'd0;
      r_flash <= 1'b0;
    end else if (bus.hit_i) begin
      r_state <= FLASH;
      r_fcnt  <= 8'd0;
      r_flash <= 1'b1;
    end else if (r_state == FLASH && r_tick) begin
      if (r_fcnt == 8'(FLASH_FRAMES - 1)) begin
        r_state <= IDLE;
        r_fcnt  <= 8'd0;
        r_flash <= 1'b0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end
  // even frames of a flash are white, odd frames show the normal picture
  assign w_white          = r_state == FLASH && !r_fcnt[0];
  assign bus.flash_active = r_flash;
`else
  logic       w_unused_hit;
  logic [7:0] w_unused_frames;
  assign w_unused_hit     = bus.hit_i;
  assign w_unused_frames  = 8'(FLASH_FRAMES);
  assign w_white          = 1'b0;
  assign bus.flash_active = 1'b0;
`endif
endmodule

// File: tb/tb_video_compositor.sv
// tb_video_compositor: table vectors, hand sequences and random stimulus against a per-pixel model
module tb_video_compositor;
  localparam int          LAT = 2;
  localparam int          FF  = 4;
  localparam int          D   = LAT + 1;
  localparam int          N   = 8192;
  localparam logic [11:0] BG  = 12'h123;
`ifdef VIDEO_COMPOSITOR_FLASH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  video_compositor_if vif();
  video_compositor #(.LAYER_LAT(LAT), .FLASH_FRAMES(FF), .BG_RGB(BG)) dut (
    .clk(clk), .reset(reset), .bus(vif)
  );
  typedef struct packed {
    logic rst, hs, vs, en, hit, sd, ad, td;
    logic [11:0] s, a, t;
  } in_t;
  typedef struct {
    bit en, sd, ad, td;
    logic [11:0] s, a, t, exp;
  } vec_t;
  in_t h[N];
  bit  tk[N];
  int  fl[N];
  int  n = 0;
  int  base = 0;
  int  compared = 0;
  int  mismatched = 0;
  int  vsq[12] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1};
  vec_t tbl[6];
  function automatic logic [11:0] pick(in_t x);
    return x.sd ? x.s : x.ad ? x.a : x.td ? x.t : BG;
  endfunction
  function automatic logic [11:0] rgb();
    return {vif.vga_r, vif.vga_g, vif.vga_b};
  endfunction
  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at step %0d: got %0h, want %0h", name, n, act, exp);
    end
  endtask
  // fl[n]: frames elapsed in the current flash during step n, -1 when no flash
  task automatic step();
    bit e_en, e_hs, e_vs, e_white;
    h[n] = {reset, vif.h_sync_i, vif.v_sync_i, vif.disp_ena_i, vif.hit_i, vif.ship_draw,
            vif.ast_draw, vif.stars_draw, vif.ship_rgb, vif.ast_rgb, vif.stars_rgb};
    @(posedge clk);
    #1;
    n++;
    if (h[n-1].rst) base = n;
    tk[n] = n - 1 >= base && !h[n-1].vs && (n - 2 < base || h[n-2].vs);
    fl[n] = (!FL || n == base) ? -1 :
            h[n-1].hit ? 0 :
            (fl[n-1] >= 0 && tk[n-1]) ? ((fl[n-1] + 1 == FF) ? -1 : fl[n-1] + 1) : fl[n-1];
    e_en    = n - D >= base && h[n-D].en;
    e_hs    = n - D >= base ? h[n-D].hs : 1'b1;
    e_vs    = n - D >= base ? h[n-D].vs : 1'b1;
    e_white = fl[n-1] >= 0 && fl[n-1] % 2 == 0;
    chk("model_hs", vif.vga_hs, e_hs);
    chk("model_vs", vif.vga_vs, e_vs);
    chk("model_rgb", rgb(), !e_en ? 12'h000 : e_white ? 12'hFFF : pick(h[n-1]));
    chk("model_tick", vif.frame_tick, tk[n]);
    chk("model_flash", vif.flash_active, fl[n] >= 0);
  endtask
  task automatic idle_in();
    reset = 1'b0;
    vif.h_sync_i = 1'b1;
    vif.v_sync_i = 1'b1;
    vif.disp_ena_i = 1'b1;
    vif.hit_i = 1'b0;
    vif.ship_draw = 1'b0;
    vif.ast_draw = 1'b0;
    vif.stars_draw = 1'b0;
    vif.ship_rgb = 12'h000;
    vif.ast_rgb = 12'h000;
    vif.stars_rgb = 12'h000;
  endtask
  // one short frame: settle, check colour/flag, then a one-step v_sync low pulse
  task automatic frame(input bit white, input bit act);
    repeat (3) step();
    chk("flash_rgb", rgb(), white ? 12'hFFF : BG);
    chk("flash_active", vif.flash_active, act);
    vif.v_sync_i = 1'b0;
    step();
    vif.v_sync_i = 1'b1;
    step();
  endtask
  initial begin
    int ticks;
    fl[0] = -1;
    tbl[0] = '{1, 1, 1, 1, 12'hF00, 12'h0F0, 12'h00F, 12'hF00};
    tbl[1] = '{1, 0, 1, 1, 12'hF00, 12'h0F0, 12'h00F, 12'h0F0};
    tbl[2] = '{1, 0, 0, 1, 12'hF00, 12'h0F0, 12'h00F, 12'h00F};
    tbl[3] = '{1, 0, 0, 0, 12'hF00, 12'h0F0, 12'h00F, BG};
    tbl[4] = '{0, 1, 1, 1, 12'hFFF, 12'h0F0, 12'h00F, 12'h000};
    tbl[5] = '{1, 1, 0, 0, 12'hABC, 12'h0F0, 12'h00F, 12'hABC};
    idle_in();
    reset = 1'b1;
    step();
    chk("reset_rgb", rgb(), 0);
    chk("reset_hs", vif.vga_hs, 1);
    chk("reset_vs", vif.vga_vs, 1);
    chk("reset_tick", vif.frame_tick, 0);
    chk("reset_flash", vif.flash_active, 0);
    reset = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      vif.disp_ena_i = tbl[i].en;
      vif.ship_draw = tbl[i].sd;
      vif.ast_draw = tbl[i].ad;
      vif.stars_draw = tbl[i].td;
      vif.ship_rgb = tbl[i].s;
      vif.ast_rgb = tbl[i].a;
      vif.stars_rgb = tbl[i].t;
      repeat (D + 1) step();
      chk("priority", rgb(), tbl[i].exp);
    end
    idle_in();
    repeat (D + 1) step();
    for (int j = 0; j < 6; j++) begin
      vif.h_sync_i = j != 0;
      vif.ship_draw = j == 2;
      vif.ship_rgb = 12'h5A5;
      step();
      chk("latency_hs", vif.vga_hs, j + 1 != 3);
      chk("latency_rgb", rgb(), j + 1 == 3 ? 12'h5A5 : BG);
    end
    idle_in();
    ticks = 0;
    for (int j = 0; j < 12; j++) begin
      vif.v_sync_i = vsq[j][0];
      step();
      ticks += int'(vif.frame_tick);
      chk("tick_pulse", vif.frame_tick, j == 2 || j == 5 || j == 9);
    end
    chk("tick_count", ticks, 3);
    idle_in();
`ifdef VIDEO_COMPOSITOR_FLASH_EN
    vif.hit_i = 1'b1;
    step();
    vif.hit_i = 1'b0;
    chk("flash_enter", vif.flash_active, 1);
    frame(1, 1);
    frame(0, 1);
    frame(1, 1);
    frame(0, 1);
    frame(0, 0);
    vif.hit_i = 1'b1;
    step();
    vif.hit_i = 1'b0;
    frame(1, 1);
    repeat (3) step();
    chk("flash_rgb", rgb(), BG);
    vif.v_sync_i = 1'b0;
    step();
    chk("tick2", vif.frame_tick, 1);
    vif.hit_i = 1'b1;
    vif.v_sync_i = 1'b1;
    step();
    vif.hit_i = 1'b0;
    frame(1, 1);
    frame(0, 1);
    frame(1, 1);
    frame(0, 1);
    frame(0, 0);
`else
    vif.hit_i = 1'b1;
    step();
    vif.hit_i = 1'b0;
    repeat (3) step();
    chk("hit_ignored_flag", vif.flash_active, 0);
    chk("hit_ignored_rgb", rgb(), BG);
`endif
    vif.hit_i = 1'b1;
    step();
    vif.hit_i = 1'b0;
    vif.h_sync_i = 1'b0;
    vif.v_sync_i = 1'b0;
    repeat (4) step();
    chk("pre_reset_flash", vif.flash_active, FL);
    chk("pre_reset_hs", vif.vga_hs, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_flash", vif.flash_active, 0);
    chk("midreset_hs", vif.vga_hs, 1);
    chk("midreset_vs", vif.vga_vs, 1);
    chk("midreset_rgb", rgb(), 0);
    repeat (2) step();
    chk("refill_hs", vif.vga_hs, 1);
    step();
    chk("refilled_hs", vif.vga_hs, 0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      vif.h_sync_i = $urandom_range(0, 15) != 0;
      vif.v_sync_i = $urandom_range(0, 19) != 0;
      vif.disp_ena_i = $urandom_range(0, 3) != 0;
      vif.hit_i = $urandom_range(0, 99) == 0;
      vif.ship_draw = 1'($urandom);
      vif.ast_draw = 1'($urandom);
      vif.stars_draw = 1'($urandom);
      vif.ship_rgb = 12'($urandom);
      vif.ast_rgb = 12'($urandom);
      vif.stars_rgb = 12'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/video_compositor.md
# video_compositor

Per-pixel layer compositor sitting directly downstream of the star-field, asteroid and ship drawing layers and upstream of the VGA DAC pins. Merges layer colours by fixed priority, blanks outside the active area, and re-times VGA sync/enable to match layer latency. Also hosts the frame-tick generator and the ship-hit screen-flash state machine.

## Interface
- `LAYER_LAT`, 1: clock cycles from `column`/`row` valid to layer `Red/Green/Blue/Draw` valid (1..4).
- `FLASH_FRAMES`, 8: frames a hit flash lasts (2..255).
- `BG_RGB`, 12'h000: background colour {R,G,B} where no layer draws.

- `clk` in 1: pixel clock.
- `reset` in 1: reset. One clock; reset is synchronous and active-high.
- `h_sync_i` in 1: VGA controller h_sync, active low.
- `v_sync_i` in 1: VGA controller v_sync, active low.
- `disp_ena_i` in 1: VGA controller active-area flag.
- `stars_rgb` in 12: star layer colour {R[3:0],G[3:0],B[3:0]}.
- `stars_draw` in 1: star layer opaque.
- `ast_rgb` in 12: asteroid layer colour. `ast_draw` in 1: asteroid opaque.
- `ship_rgb` in 12: ship layer colour. `ship_draw` in 1: ship opaque.
- `hit_i` in 1: one-cycle ship-hit pulse from game logic.
- `vga_r`, `vga_g`, `vga_b` out 4 each: pixel colour to DAC.
- `vga_hs`, `vga_vs` out 1: delayed syncs, active low.
- `frame_tick` out 1: one-cycle pulse per frame.
- `flash_active` out 1: high while flash FSM is not IDLE.

## Operation
- Priority, highest first: ship, asteroid, stars, `BG_RGB`.
- Sync/enable alignment: `h_sync_i`, `v_sync_i`, `disp_ena_i` pass through a `LAYER_LAT`-deep delay line, then the common output register.
- Colour pick uses delayed `disp_ena`; when low, output 12'h000 regardless of layers.
- `frame_tick`: registered detect of `v_sync_i` 1→0 (undelayed input); high exactly one cycle per falling edge. First edge after reset counts (prior-sample register resets to 1).
- Flash FSM (`FLASH_EN` builds only):
  - States IDLE, FLASH; 8-bit frame counter `fcnt`.
  - IDLE: `hit_i`=1 → FLASH, `fcnt`=0.
  - FLASH: each `frame_tick` increments `fcnt`; when `fcnt`=`FLASH_FRAMES`-1 and `frame_tick`=1 → IDLE.
  - `hit_i` in FLASH restarts `fcnt`=0, stays FLASH.
  - `hit_i` and `frame_tick` same cycle: hit wins, tick not counted.
  - In FLASH with `fcnt[0]`=0, active-area output forced to 12'hFFF; with `fcnt[0]`=1, normal composition. Blanking still wins.
- `flash_active` = (state==FLASH), registered with the state.

## Timing
- Reset values: `vga_r/g/b`=0, `vga_hs`=1, `vga_vs`=1, `frame_tick`=0, `flash_active`=0; delay-line sync stages=1, enable stages=0; FSM=IDLE, `fcnt`=0.
- Sync/enable latency: input at edge t → `vga_hs/vs` and blanking decision at t+`LAYER_LAT`+1.
- Layer latency: layer inputs at edge t+`LAYER_LAT` → `vga_r/g/b` at t+`LAYER_LAT`+1. Colour and syncs for one pixel leave together.
- `frame_tick` latency: 1 cycle after `v_sync_i` falls.
- Flash forcing applies from the first output cycle after the FSM enters FLASH, including mid-line. Once IDLE, it stops at the next cycle.
- Reset mid-frame or mid-flash: all state returns to reset values next edge; delay line refills, no stale sync emitted.

## Configuration
- `VIDEO_COMPOSITOR_FLASH_EN` defined: flash FSM and `fcnt` built as above.
- Undefined: no FSM or counter; `hit_i` ignored; `flash_active` tied 0; output is pure priority composition. `frame_tick` is present in both builds.

## Test plan
- Priority: `disp_ena_i`=1, `ship_draw`=`ast_draw`=`stars_draw`=1, `ship_rgb`=12'hF00, `ast_rgb`=12'h0F0 → RGB=F,0,0. Drop `ship_draw` → 0,F,0. Drop all → `BG_RGB`.
- Latency, `LAYER_LAT`=2: single-cycle `h_sync_i` low at cycle 10 → `vga_hs` low only at cycle 13. Matching layer pixel valid at 12 appears at 13.
- Blanking: `disp_ena_i`=0, `ship_draw`=1 with 12'hFFF → output 0,0,0.
- Frame tick: three `v_sync_i` falling edges → exactly three one-cycle `frame_tick` pulses, each 1 cycle after its edge.
- Flash, `FLASH_FRAMES`=4: `hit_i` pulse, then 4 ticks → white, normal, white, normal across frames; IDLE after the 4th tick. A second `hit_i` coincident with tick 2 restarts at white and extends to 4 more frames.
- Reset mid-flash: assert `reset` while FLASH → next cycle `flash_active`=0, `vga_hs`=`vga_vs`=1, RGB=0.
